// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style control FSM for a multicycle RV32-subset datapath. Each
// instruction walks FETCH -> DECODE -> class-specific states -> FETCH.
// Memory states (FETCH, MEM_RD, MEM_WR) wait on mem_ready_i. A bounded wait
// counter turns a stuck bus into a sticky bus fault. An unknown opcode gives a
// sticky illegal-opcode fault. Both faults park the FSM in FAULT until reset.
//
// Parameters:
//   MEM_TIMEOUT     cycles a memory state may wait for mem_ready_i (>= 1)
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   op_i, funct3_i  instruction opcode [6:0] and funct3 [14:12]
//   zero_i          ALU zero flag, used by BRANCH
//   mem_ready_i     memory completion handshake
//   mem_req_o, mem_write_o, mem_addr_src_o    memory request controls
//   ir_write_o, pc_write_o, old_pc_write_o, reg_write_o   write strobes
//   alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o      datapath selects
//   fault_o         0 none, 1 illegal opcode, 2 bus timeout (sticky)
//   state_o         current state, for debug
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       mem_addr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       old_pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic [1:0] fault_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_FAULT    = 4'd12;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_BUS     = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [1:0]       fault_q;
  logic [1:0]       fault_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_wait_state;
  logic             timeout;

  // wait_cnt holds the number of cycles already spent waiting in the current
  // memory state, so the MEM_TIMEOUT-th waiting cycle is the one that sees
  // CNT_LAST. A ready on that same cycle still wins over the timeout.
  always_comb begin
    mem_wait_state = (state == S_FETCH) || (state == S_MEM_RD) ||
                     (state == S_MEM_WR);
    timeout        = mem_wait_state && !mem_ready_i && (wait_cnt == CNT_LAST);
  end

  always_comb begin
    state_next = state;
    fault_next = fault_q;
    case (state)
      S_FETCH: begin
        if (mem_ready_i) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
          fault_next = FAULT_BUS;
        end
      end
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default: begin
            state_next = S_FAULT;
            fault_next = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (op_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready_i) begin
          state_next = S_MEM_WB;
        end else if (timeout) begin
          state_next = S_FAULT;
          fault_next = FAULT_BUS;
        end
      end
      S_MEM_WR: begin
        if (mem_ready_i) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_FAULT;
          fault_next = FAULT_BUS;
        end
      end
      S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_LUI: state_next = S_FETCH;
      S_FAULT: state_next = S_FAULT;
      // Unused encodings recover to FETCH.
      default: state_next = S_FETCH;
    endcase
  end

  // State, fault and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      fault_q  <= FAULT_NONE;
      wait_cnt <= '0;
    end else begin
      state   <= state_next;
      fault_q <= fault_next;
      // Any state change clears the counter, so every memory state starts
      // counting from zero on entry.
      if ((state_next != state) || !mem_wait_state) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Output decode from the registered state. FETCH strobes are qualified by
  // the handshake, BRANCH's pc_write_o by the compare result.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_write_o    = 1'b0;
    mem_addr_src_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    old_pc_write_o = 1'b0;
    reg_write_o    = 1'b0;
    alu_src_a_o    = 2'd0;
    alu_src_b_o    = 2'd0;
    alu_op_o       = 2'd0;
    result_src_o   = 2'd0;
    case (state)
      S_FETCH: begin
        mem_req_o      = 1'b1;
        alu_src_b_o    = 2'd2;
        ir_write_o     = mem_ready_i;
        pc_write_o     = mem_ready_i;
        old_pc_write_o = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'd1;
        alu_src_b_o = 2'd1;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 2'd2;
        alu_src_b_o = 2'd1;
      end
      S_MEM_RD: begin
        mem_req_o      = 1'b1;
        mem_addr_src_o = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'd1;
      end
      S_MEM_WR: begin
        mem_req_o      = 1'b1;
        mem_write_o    = 1'b1;
        mem_addr_src_o = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'd2;
        alu_op_o    = 2'd2;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'd2;
        alu_src_b_o = 2'd1;
        alu_op_o    = 2'd2;
      end
      S_ALU_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o = 2'd2;
        alu_op_o    = 2'd1;
        case (funct3_i)
          3'b000:  pc_write_o = zero_i;
          3'b001:  pc_write_o = !zero_i;
          default: pc_write_o = 1'b0;
        endcase
      end
      S_JAL: begin
        reg_write_o = 1'b1;
        pc_write_o  = 1'b1;
        alu_src_a_o = 2'd1;
        alu_src_b_o = 2'd2;
      end
      S_LUI: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'd2;
      end
      default: begin
      end
    endcase
  end

  assign fault_o = fault_q;
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Each scenario task queues per-cycle stimulus together with the outputs the
// control unit must show in that cycle, then plays the queue: inputs are
// applied just after the falling edge, outputs are compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_write_o, mem_addr_src_o;
  logic       ir_write_o, pc_write_o, old_pc_write_o, reg_write_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, fault_o;
  logic [3:0] state_o;

  multicycle_control_unit #(.MEM_TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .op_i           (op_i),
    .funct3_i       (funct3_i),
    .zero_i         (zero_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_src_o (mem_addr_src_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .old_pc_write_o (old_pc_write_o),
    .reg_write_o    (reg_write_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .result_src_o   (result_src_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero;
    logic       rdy;
  } stim_t;

  // main = {state, fault, req, write, addr_src, ir_w, pc_w, old_pc_w, reg_w}
  typedef struct packed {
    logic [12:0] main;
    logic        sel_chk;
    logic [5:0]  sel;     // {alu_src_a, alu_src_b, alu_op}
    logic        res_chk;
    logic [1:0]  res;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [12:0] obs_main;
  logic [5:0]  obs_sel;
  assign obs_main = {state_o, fault_o, mem_req_o, mem_write_o, mem_addr_src_o,
                     ir_write_o, pc_write_o, old_pc_write_o, reg_write_o};
  assign obs_sel  = {alu_src_a_o, alu_src_b_o, alu_op_o};

  function automatic exp_t mk(input logic [3:0] st, input logic [1:0] f,
                              input logic req, input logic wr, input logic as,
                              input logic iw, input logic pw, input logic opw,
                              input logic rw);
    exp_t e;
    e = '0;
    e.main = {st, f, req, wr, as, iw, pw, opw, rw};
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic r);
    exp_t e;
    e = mk(4'd0, 2'd0, 1, 0, 0, r, r, r, 0);
    e.sel_chk = 1'b1; e.sel = {2'd0, 2'd2, 2'd0};
    return e;
  endfunction
  function automatic exp_t e_decode();
    exp_t e;
    e = mk(4'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    e.sel_chk = 1'b1; e.sel = {2'd1, 2'd1, 2'd0};
    return e;
  endfunction
  function automatic exp_t e_maddr();
    exp_t e;
    e = mk(4'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    e.sel_chk = 1'b1; e.sel = {2'd2, 2'd1, 2'd0};
    return e;
  endfunction
  function automatic exp_t e_mrd();
    return mk(4'd3, 2'd0, 1, 0, 1, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_mwb();
    exp_t e;
    e = mk(4'd4, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    e.res_chk = 1'b1; e.res = 2'd1;
    return e;
  endfunction
  function automatic exp_t e_mwr();
    return mk(4'd5, 2'd0, 1, 1, 1, 0, 0, 0, 0);
  endfunction
  function automatic exp_t e_exec(input logic imm);
    exp_t e;
    e = mk(imm ? 4'd7 : 4'd6, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    e.sel_chk = 1'b1; e.sel = {2'd2, imm ? 2'd1 : 2'd0, 2'd2};
    return e;
  endfunction
  function automatic exp_t e_awb();
    exp_t e;
    e = mk(4'd8, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    e.res_chk = 1'b1; e.res = 2'd0;
    return e;
  endfunction
  function automatic exp_t e_branch(input logic p);
    exp_t e;
    e = mk(4'd9, 2'd0, 0, 0, 0, 0, p, 0, 0);
    e.sel_chk = 1'b1; e.sel = {2'd2, 2'd0, 2'd1};
    e.res_chk = 1'b1; e.res = 2'd0;
    return e;
  endfunction
  function automatic exp_t e_jal();
    exp_t e;
    e = mk(4'd10, 2'd0, 0, 0, 0, 0, 1, 0, 1);
    e.res_chk = 1'b1; e.res = 2'd0;
    return e;
  endfunction
  function automatic exp_t e_lui();
    exp_t e;
    e = mk(4'd11, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    e.res_chk = 1'b1; e.res = 2'd2;
    return e;
  endfunction
  function automatic exp_t e_fault(input logic [1:0] f);
    return mk(4'd12, f, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                      input logic zero, input logic rdy, input exp_t e);
    stim_q.push_back({rst, op, f3, zero, rdy});
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b1; mem_ready_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) push(0, 7'h33, 3'd0, 0, 0, e_fetch(0));
    push(0, 7'h33, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h33, 3'd0, 0, 0, e_decode());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL reset step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      if (e.sel_chk) begin
        vectors++;
        if (obs_sel !== e.sel) begin
          miscompares++;
          $display("FAIL reset step %0d: alu sel got %h required %h", n, obs_sel, e.sel);
        end
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    push(0, 7'h33, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h33, 3'd0, 0, 1, e_decode());
    push(0, 7'h33, 3'd0, 0, 1, e_exec(0));
    push(0, 7'h33, 3'd0, 0, 1, e_awb());
    push(0, 7'h33, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h33, 3'd0, 0, 1, e_decode());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL add step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      if (e.sel_chk) begin
        vectors++;
        if (obs_sel !== e.sel) begin
          miscompares++;
          $display("FAIL add step %0d: alu sel got %h required %h", n, obs_sel, e.sel);
        end
      end
      if (e.res_chk) begin
        vectors++;
        if (result_src_o !== e.res) begin
          miscompares++;
          $display("FAIL add step %0d: result_src got %0d required %0d", n, result_src_o, e.res);
        end
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_load_store();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    // Load: ready arrives on the 4th MEM_RD cycle -> 8 cycles in total.
    push(0, 7'h03, 3'd2, 0, 1, e_fetch(1));
    push(0, 7'h03, 3'd2, 0, 1, e_decode());
    push(0, 7'h03, 3'd2, 0, 1, e_maddr());
    for (int i = 0; i < 3; i++) push(0, 7'h03, 3'd2, 0, 0, e_mrd());
    push(0, 7'h03, 3'd2, 0, 1, e_mrd());
    push(0, 7'h03, 3'd2, 0, 1, e_mwb());
    // Store with two wait cycles.
    push(0, 7'h23, 3'd2, 0, 1, e_fetch(1));
    push(0, 7'h23, 3'd2, 0, 1, e_decode());
    push(0, 7'h23, 3'd2, 0, 1, e_maddr());
    push(0, 7'h23, 3'd2, 0, 0, e_mwr());
    push(0, 7'h23, 3'd2, 0, 0, e_mwr());
    push(0, 7'h23, 3'd2, 0, 1, e_mwr());
    push(0, 7'h23, 3'd2, 0, 0, e_fetch(0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL load_store step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      if (e.sel_chk) begin
        vectors++;
        if (obs_sel !== e.sel) begin
          miscompares++;
          $display("FAIL load_store step %0d: alu sel got %h required %h", n, obs_sel, e.sel);
        end
      end
      if (e.res_chk) begin
        vectors++;
        if (result_src_o !== e.res) begin
          miscompares++;
          $display("FAIL load_store step %0d: result_src got %0d required %0d", n, result_src_o, e.res);
        end
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    stim_t s; exp_t e; int n = 0;
    logic [2:0] f3_tab[5]  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    logic       z_tab[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       p_tab[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      push(0, 7'h63, f3_tab[i], z_tab[i], 1, e_fetch(1));
      push(0, 7'h63, f3_tab[i], z_tab[i], 1, e_decode());
      push(0, 7'h63, f3_tab[i], z_tab[i], 1, e_branch(p_tab[i]));
    end
    push(0, 7'h63, 3'd0, 0, 0, e_fetch(0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL branch step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      if (e.sel_chk) begin
        vectors++;
        if (obs_sel !== e.sel) begin
          miscompares++;
          $display("FAIL branch step %0d: alu sel got %h required %h", n, obs_sel, e.sel);
        end
      end
      if (e.res_chk) begin
        vectors++;
        if (result_src_o !== e.res) begin
          miscompares++;
          $display("FAIL branch step %0d: result_src got %0d required %0d", n, result_src_o, e.res);
        end
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    push(0, 7'h6F, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h6F, 3'd0, 0, 1, e_decode());
    push(0, 7'h6F, 3'd0, 0, 1, e_jal());
    push(0, 7'h37, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h37, 3'd0, 0, 1, e_decode());
    push(0, 7'h37, 3'd0, 0, 1, e_lui());
    push(0, 7'h13, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h13, 3'd0, 0, 1, e_decode());
    push(0, 7'h13, 3'd0, 0, 1, e_exec(1));
    push(0, 7'h13, 3'd0, 0, 1, e_awb());
    push(0, 7'h13, 3'd0, 0, 0, e_fetch(0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      if (e.sel_chk) begin
        vectors++;
        if (obs_sel !== e.sel) begin
          miscompares++;
          $display("FAIL back_to_back step %0d: alu sel got %h required %h", n, obs_sel, e.sel);
        end
      end
      if (e.res_chk) begin
        vectors++;
        if (result_src_o !== e.res) begin
          miscompares++;
          $display("FAIL back_to_back step %0d: result_src got %0d required %0d", n, result_src_o, e.res);
        end
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    push(0, 7'h7F, 3'd0, 0, 1, e_fetch(1));
    push(0, 7'h7F, 3'd0, 0, 1, e_decode());
    for (int i = 0; i < 22; i++)
      push(0, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_fault(2'd1));
    push(1, 7'h33, 3'd0, 0, 1, e_fault(2'd1));
    push(0, 7'h33, 3'd0, 0, 0, e_fetch(0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL illegal step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    // FETCH starved for the full window.
    for (int i = 0; i < 16; i++) push(0, 7'h23, 3'd2, 0, 0, e_fetch(0));
    push(0, 7'h23, 3'd2, 0, 1, e_fault(2'd2));
    push(1, 7'h23, 3'd2, 0, 1, e_fault(2'd2));
    // MEM_WR starved for 16 cycles.
    push(0, 7'h23, 3'd2, 0, 1, e_fetch(1));
    push(0, 7'h23, 3'd2, 0, 1, e_decode());
    push(0, 7'h23, 3'd2, 0, 1, e_maddr());
    for (int i = 0; i < 16; i++) push(0, 7'h23, 3'd2, 0, 0, e_mwr());
    for (int i = 0; i < 3; i++) push(0, 7'h23, 3'd2, 0, 1, e_fault(2'd2));
    push(1, 7'h23, 3'd2, 0, 0, e_fault(2'd2));
    // Ready on exactly the 16th MEM_WR cycle is still a success.
    push(0, 7'h23, 3'd2, 0, 1, e_fetch(1));
    push(0, 7'h23, 3'd2, 0, 1, e_decode());
    push(0, 7'h23, 3'd2, 0, 1, e_maddr());
    for (int i = 0; i < 15; i++) push(0, 7'h23, 3'd2, 0, 0, e_mwr());
    push(0, 7'h23, 3'd2, 0, 1, e_mwr());
    push(0, 7'h23, 3'd2, 0, 0, e_fetch(0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL timeout step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    stim_t s; exp_t e; int n = 0;
    apply_reset();
    push(0, 7'h03, 3'd2, 0, 1, e_fetch(1));
    push(0, 7'h03, 3'd2, 0, 1, e_decode());
    push(0, 7'h03, 3'd2, 0, 1, e_maddr());
    push(0, 7'h03, 3'd2, 0, 0, e_mrd());
    push(0, 7'h03, 3'd2, 0, 0, e_mrd());
    // Ready and reset together: reset wins, no MEM_WB write-back.
    push(1, 7'h03, 3'd2, 0, 1, e_mrd());
    push(0, 7'h03, 3'd2, 0, 0, e_fetch(0));
    push(0, 7'h03, 3'd2, 0, 0, e_fetch(0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      reset = s.rst; op_i = s.op; funct3_i = s.f3; zero_i = s.zero; mem_ready_i = s.rdy;
      #1;
      vectors++;
      if (obs_main !== e.main) begin
        miscompares++;
        $display("FAIL reset_mid_read step %0d: outputs got %h required %h", n, obs_main, e.main);
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op_i = 7'h00; funct3_i = 3'd0; zero_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_add();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, max cycles any memory state waits for mem_ready_i before a bus fault.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  reset is synchronous and active-high.
REQ-004 Port: op_i  in  7  opcode field of the instruction register, bits [6:0].
REQ-005 Port: funct3_i  in  3  instruction bits [14:12].
REQ-006 Port: zero_i  in  1  ALU zero flag.
REQ-007 Port: mem_ready_i  in  1  memory completion handshake.
REQ-008 Port: mem_req_o  out  1  memory access request.
REQ-009 Port: mem_write_o  out  1  store strobe, qualified by mem_req_o.
REQ-010 Port: mem_addr_src_o  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 Port: ir_write_o, pc_write_o, old_pc_write_o, reg_write_o  out  1 each  write strobes.
REQ-012 Port: alu_src_a_o  out  2  ALU A select: 0 = PC, 1 = old PC, 2 = rs1.
REQ-013 Port: alu_src_b_o  out  2  ALU B select: 0 = rs2, 1 = immediate, 2 = constant 4.
REQ-014 Port: alu_op_o  out  2  ALU operation class: 0 = add, 1 = sub, 2 = decode from funct fields.
REQ-015 Port: result_src_o  out  2  write-back select: 0 = ALU result register, 1 = memory data, 2 = ALU output.
REQ-016 Port: fault_o  out  2  sticky fault: 0 = none, 1 = illegal opcode, 2 = bus timeout.
REQ-017 Port: state_o  out  4  current state encoding, for debug.

Function
REQ-018 The block SHALL be a Moore FSM; every output SHALL decode from the registered state, except pc_write_o in BRANCH and the handshake-qualified strobes below.
REQ-019 State encoding SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, LUI=11, FAULT=12.
REQ-020 In FETCH, the block SHALL drive mem_req_o=1, mem_addr_src_o=0, alu_src_a_o=0, alu_src_b_o=2 and alu_op_o=0.
REQ-021 ir_write_o, pc_write_o and old_pc_write_o SHALL each pulse for exactly the one FETCH cycle in which mem_ready_i=1; the FSM SHALL then go to DECODE.
REQ-022 While mem_ready_i=0 in FETCH, the block SHALL stay in FETCH with all write strobes at 0.
REQ-023 DECODE SHALL last one cycle, drive alu_src_a_o=1, alu_src_b_o=1 and alu_op_o=0, and branch on op_i as follows:
  - 0x03 or 0x23 -> MEM_ADDR
  - 0x33 -> EXEC_R
  - 0x13 -> EXEC_I
  - 0x63 -> BRANCH
  - 0x6F -> JAL
  - 0x37 -> LUI
  - any other value -> FAULT, with fault_o=1
REQ-024 MEM_ADDR SHALL drive alu_src_a_o=2, alu_src_b_o=1 and alu_op_o=0, then go to MEM_RD if op_i=0x03, else to MEM_WR.
REQ-025 MEM_RD SHALL drive mem_req_o=1 and mem_addr_src_o=1, and go to MEM_WB on mem_ready_i=1.
REQ-026 MEM_WR SHALL drive mem_req_o=1, mem_write_o=1 and mem_addr_src_o=1, and go to FETCH on mem_ready_i=1.
REQ-027 MEM_WB SHALL drive reg_write_o=1 and result_src_o=1, then go to FETCH.
REQ-028 EXEC_R SHALL drive alu_src_a_o=2, alu_src_b_o=0 and alu_op_o=2; EXEC_I SHALL be identical except alu_src_b_o=1; both SHALL go to ALU_WB.
REQ-029 ALU_WB SHALL drive reg_write_o=1 and result_src_o=0, then go to FETCH.
REQ-030 BRANCH SHALL drive alu_src_a_o=2, alu_src_b_o=0, alu_op_o=1 and result_src_o=0; pc_write_o SHALL be zero_i when funct3_i=000 and NOT zero_i when funct3_i=001; any other funct3 SHALL give pc_write_o=0; the FSM SHALL then go to FETCH.
REQ-031 JAL SHALL drive reg_write_o=1, pc_write_o=1, alu_src_a_o=1, alu_src_b_o=2 and result_src_o=0, then go to FETCH.
REQ-032 LUI SHALL drive reg_write_o=1 and result_src_o=2, then go to FETCH.
REQ-033 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each waiting cycle.
REQ-034 When the wait counter reaches MEM_TIMEOUT without mem_ready_i, the FSM SHALL enter FAULT with fault_o=2.
REQ-035 mem_ready_i=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success.
REQ-036 FAULT SHALL be absorbing: all strobes 0, mem_req_o=0, fault_o held, until reset.
REQ-037 mem_ready_i SHALL be ignored in every state other than FETCH, MEM_RD and MEM_WR.

Reset
REQ-038 When reset=1 at a rising edge, the block SHALL set the state to FETCH, clear the wait counter and set fault_o=0, regardless of the current state or any outstanding handshake.
REQ-039 In the first cycle after reset, outputs SHALL be the FETCH values: mem_req_o=1 and all write strobes 0.

Verification
REQ-040 Add: reset, mem_ready_i=1 every cycle, op_i=0x33 -> 4 cycles FETCH, DECODE, EXEC_R, ALU_WB; reg_write_o=1 only in ALU_WB.
REQ-041 Load: op_i=0x03, mem_ready_i late by 3 cycles in MEM_RD -> 5 + 3 = 8 cycles total; result_src_o=1 in MEM_WB.
REQ-042 Branch: op_i=0x63, funct3_i=000, zero_i=1 -> pc_write_o=1 in BRANCH; zero_i=0 -> pc_write_o=0.
REQ-043 Illegal opcode: op_i=0x7F -> DECODE goes to FAULT, fault_o=1 held for 20+ cycles, mem_req_o=0.
REQ-044 Timeout: mem_ready_i=0 in MEM_WR for 16 cycles -> FAULT, fault_o=2; a repeat with ready on cycle 16 -> FETCH.
REQ-045 Reset mid-MEM_RD -> next state_o=0, fault_o=0, no reg_write_o pulse.
